// File: rtl/sound_mem_pkg.sv
// rtl/sound_mem_pkg.sv - shared constants and state encoding for the sound/memory front end
// Contents:
//   ADDR_W            width of the captured host address
//   ST_* / state_e    address deserializer state encoding
//   SOUND_ADDR_DECODE upper address byte decoded as the sound chip window
package sound_mem_pkg;

    localparam int ADDR_W = 16;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_LOAD   = 3'd1;
    localparam logic [2:0] ST_SAMPLE = 3'd2;
    localparam logic [2:0] ST_CLKHI  = 3'd3;
    localparam logic [2:0] ST_DONE   = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE   = ST_IDLE,
        S_LOAD   = ST_LOAD,
        S_SAMPLE = ST_SAMPLE,
        S_CLKHI  = ST_CLKHI,
        S_DONE   = ST_DONE
    } state_e;

    localparam logic [7:0] SOUND_ADDR_DECODE = 8'h84;

endpackage

// File: rtl/sync_ff.sv
// rtl/sync_ff.sv - multi-stage synchroniser for an asynchronous single-bit input
// Ports:
//   clk     system clock
//   resetn  asynchronous active-low reset; every stage resets to 1
//   d       asynchronous input
//   q       synchronised output (last stage)
module sync_ff #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic resetn,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] stages_q;
    logic [STAGES-1:0] stages_d;

    if (STAGES > 1) begin : g_chain
        assign stages_d = {stages_q[STAGES-2:0], d};
    end else begin : g_single
        assign stages_d = d;
    end

    // Reset to 1 so an idle-high strobe never looks like a falling edge after reset.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            stages_q <= '1;
        end else begin
            stages_q <= stages_d;
        end
    end

    assign q = stages_q[STAGES-1];

endmodule

// File: rtl/addr_deserializer.sv
// rtl/addr_deserializer.sv - captures the host address from two external shift chains on each MEMEN fall
// Ports:
//   clk        system clock
//   reset      asynchronous active-low reset
//   memen      host MEMEN (active low, asynchronous)
//   a15        host A15 (asynchronous)
//   adrin1     serial data from chain 1 (A0..A7, MSB first)
//   adrin2     serial data from chain 2 (A8..A14, then an unused bit)
//   o_shld     chain shift/load (0 = load, 1 = shift)
//   o_serclk   chain shift clock (rising edge shifts)
//   o_address  captured address, bit15 = TI A0 ... bit0 = TI A15
//   o_valid    one-cycle strobe when o_address updates
//   o_busy     capture in progress
module addr_deserializer
    import sound_mem_pkg::*;
#(
    parameter int CLK_DIV     = 2,
    parameter int LOAD_CYCLES = 2,
    parameter int CHAIN_BITS  = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              memen,
    input  logic              a15,
    input  logic              adrin1,
    input  logic              adrin2,
    output logic              o_shld,
    output logic              o_serclk,
    output logic [ADDR_W-1:0] o_address,
    output logic              o_valid,
    output logic              o_busy
);

    localparam int DIV_W = 8;
    localparam int CNT_W = $clog2(CHAIN_BITS);
    localparam logic [DIV_W-1:0] CLK_LAST  = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0] LOAD_LAST = DIV_W'(LOAD_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CHAIN_BITS - 1);

    logic memen_s;
    logic a15_s;

    sync_ff #(.STAGES(SYNC_STAGES)) u_memen_sync (
        .clk    (clk),
        .resetn (reset),
        .d      (memen),
        .q      (memen_s)
    );

    sync_ff #(.STAGES(SYNC_STAGES)) u_a15_sync (
        .clk    (clk),
        .resetn (reset),
        .d      (a15),
        .q      (a15_s)
    );

    state_e                  state_q, state_d;
    logic [DIV_W-1:0]        div_q, div_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [CHAIN_BITS-1:0]   sr1_q, sr1_d;
    logic [CHAIN_BITS-1:0]   sr2_q, sr2_d;
    logic                    hold_q, hold_d;
    logic [ADDR_W-1:0]       addr_q, addr_d;
    logic                    shld_q, shld_d;
    logic                    serclk_q, serclk_d;
    logic                    valid_q, valid_d;
    logic                    busy_q, busy_d;
    logic                    memen_prev_q, memen_prev_d;
    logic                    memen_fall;

    // The previous-sample flop tracks memen_s in every state, so a fall that
    // happens while busy is consumed and never replayed once back in IDLE.
    assign memen_fall = memen_prev_q & ~memen_s;

    always_comb begin
        state_d      = state_q;
        div_d        = div_q;
        cnt_d        = cnt_q;
        sr1_d        = sr1_q;
        sr2_d        = sr2_q;
        hold_d       = hold_q;
        addr_d       = addr_q;
        shld_d       = 1'b1;
        serclk_d     = 1'b0;
        valid_d      = 1'b0;
        busy_d       = busy_q;
        memen_prev_d = memen_s;

        // Output flops carry the value for the state being entered, so the
        // pins change on the same edge as the state register.
        case (state_q)
            S_IDLE: begin
                busy_d = 1'b0;
                if (memen_fall) begin
                    state_d = S_LOAD;
                    div_d   = '0;
                    hold_d  = a15_s;
                    busy_d  = 1'b1;
                    shld_d  = 1'b0;
                end
            end
            S_LOAD: begin
                if (memen_s) begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                end else if (div_q == LOAD_LAST) begin
                    state_d = S_SAMPLE;
                    div_d   = '0;
                    cnt_d   = '0;
                end else begin
                    div_d  = div_q + 1'b1;
                    shld_d = 1'b0;
                end
            end
            S_SAMPLE: begin
                if (memen_s) begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                end else if (div_q == CLK_LAST) begin
                    // Chain output is stable here: the next rising SRCLK is
                    // launched on this same edge.
                    sr1_d = {sr1_q[CHAIN_BITS-2:0], adrin1};
                    sr2_d = {sr2_q[CHAIN_BITS-2:0], adrin2};
                    div_d = '0;
                    if (cnt_q == CNT_LAST) begin
                        state_d = S_DONE;
                    end else begin
                        state_d  = S_CLKHI;
                        serclk_d = 1'b1;
                    end
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            S_CLKHI: begin
                if (memen_s) begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                end else if (div_q == CLK_LAST) begin
                    state_d = S_SAMPLE;
                    div_d   = '0;
                    cnt_d   = cnt_q + 1'b1;
                end else begin
                    div_d    = div_q + 1'b1;
                    serclk_d = 1'b1;
                end
            end
            S_DONE: begin
                // Last bit of chain 2 is a spare position on the board.
                addr_d  = {sr1_q, sr2_q[CHAIN_BITS-1:1], hold_q};
                valid_d = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            div_q        <= '0;
            cnt_q        <= '0;
            sr1_q        <= '0;
            sr2_q        <= '0;
            hold_q       <= 1'b0;
            addr_q       <= '0;
            shld_q       <= 1'b1;
            serclk_q     <= 1'b0;
            valid_q      <= 1'b0;
            busy_q       <= 1'b0;
            memen_prev_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            div_q        <= div_d;
            cnt_q        <= cnt_d;
            sr1_q        <= sr1_d;
            sr2_q        <= sr2_d;
            hold_q       <= hold_d;
            addr_q       <= addr_d;
            shld_q       <= shld_d;
            serclk_q     <= serclk_d;
            valid_q      <= valid_d;
            busy_q       <= busy_d;
            memen_prev_q <= memen_prev_d;
        end
    end

    assign o_shld    = shld_q;
    assign o_serclk  = serclk_q;
    assign o_address = addr_q;
    assign o_valid   = valid_q;
    assign o_busy    = busy_q;

endmodule

// File: tb/tb_addr_deserializer.sv
// tb/tb_addr_deserializer.sv - self-checking bench for addr_deserializer (default and fast parameter sets)
module tb_addr_deserializer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        memen1, memen2, a15;
    logic        adrin1, adrin2;
    logic        shld1, serclk1, valid1, busy1;
    logic        shld2, serclk2, valid2, busy2;
    logic [15:0] addr1, addr2;

    addr_deserializer #(.CLK_DIV(2), .LOAD_CYCLES(2), .CHAIN_BITS(8), .SYNC_STAGES(2)) dut1 (
        .clk(clk), .reset(reset), .memen(memen1), .a15(a15), .adrin1(adrin1), .adrin2(adrin2),
        .o_shld(shld1), .o_serclk(serclk1), .o_address(addr1), .o_valid(valid1), .o_busy(busy1)
    );

    addr_deserializer #(.CLK_DIV(1), .LOAD_CYCLES(1), .CHAIN_BITS(8), .SYNC_STAGES(2)) dut2 (
        .clk(clk), .reset(reset), .memen(memen2), .a15(a15), .adrin1(adrin1), .adrin2(adrin2),
        .o_shld(shld2), .o_serclk(serclk2), .o_address(addr2), .o_valid(valid2), .o_busy(busy2)
    );

    // One pair of external '165-style chains shared by both DUTs; only one
    // DUT is ever capturing, the idle one holds shld=1 and serclk=0.
    logic [7:0] chain1_val, chain2_val;
    logic [7:0] ch1, ch2;
    logic       shld_m, serclk_m;
    assign shld_m   = shld1 & shld2;
    assign serclk_m = serclk1 | serclk2;
    assign adrin1   = ch1[7];
    assign adrin2   = ch2[7];

    always @(posedge serclk_m or negedge shld_m) begin
        #1;
        if (!shld_m) begin
            ch1 = chain1_val;
            ch2 = chain2_val;
        end else begin
            ch1 = {ch1[6:0], 1'b0};
            ch2 = {ch2[6:0], 1'b0};
        end
    end

    int serclk_rises = 0;
    int shld_falls   = 0;
    int shld_low_cyc = 0;
    int vcount1      = 0;
    int vcount2      = 0;
    logic [15:0] cap1_q[$];

    always @(posedge serclk_m) serclk_rises++;
    always @(negedge shld_m) shld_falls++;
    always @(posedge clk) begin
        if (!shld_m) shld_low_cyc++;
        if (valid1) begin
            vcount1++;
            cap1_q.push_back(addr1);
        end
        if (valid2) vcount2++;
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_memen(input int sel, input logic v);
        if (sel != 0) memen2 = v;
        else          memen1 = v;
    endtask

    function automatic logic busy_of(input int sel);
        return (sel != 0) ? busy2 : busy1;
    endfunction

    function automatic logic valid_of(input int sel);
        return (sel != 0) ? valid2 : valid1;
    endfunction

    function automatic logic [15:0] addr_of(input int sel);
        return (sel != 0) ? addr2 : addr1;
    endfunction

    // Reference: high byte is chain 1 as loaded, next seven bits are the
    // first seven bits out of chain 2, LSB is A15.
    function automatic logic [15:0] ref_addr(input logic [7:0] c1, input logic [7:0] c2, input logic a);
        int v;
        v = int'(c1) * 256 + (int'(c2) / 2) * 2 + int'(a);
        return v[15:0];
    endfunction

    function automatic int div_of(input int sel);
        return (sel != 0) ? 1 : 2;
    endfunction

    function automatic int load_of(input int sel);
        return (sel != 0) ? 1 : 2;
    endfunction

    function automatic int ref_latency(input int sel);
        return load_of(sel) + (2 * 8 - 1) * div_of(sel) + 1;
    endfunction

    task automatic run_capture(input string tag, input int sel, input logic [7:0] c1,
                               input logic [7:0] c2, input logic a, input logic [15:0] exp);
        int r0, f0, l0, v0, k, lat;
        chain1_val = c1;
        chain2_val = c2;
        a15        = a;
        repeat (4) tick();
        r0 = serclk_rises;
        f0 = shld_falls;
        l0 = shld_low_cyc;
        v0 = (sel != 0) ? vcount2 : vcount1;
        set_memen(sel, 1'b0);
        k = 0;
        while (!busy_of(sel) && k < 8) begin
            tick();
            k++;
        end
        check({tag, " busy_rise"}, int'(busy_of(sel)), 1);
        lat = 0;
        while (!valid_of(sel) && lat < 80) begin
            tick();
            lat++;
        end
        check({tag, " latency"}, lat, ref_latency(sel));
        check({tag, " address"}, int'(addr_of(sel)), int'(exp));
        check({tag, " busy_after"}, int'(busy_of(sel)), 0);
        repeat (25) tick();
        set_memen(sel, 1'b1);
        repeat (6) tick();
        check({tag, " valid_pulses"}, ((sel != 0) ? vcount2 : vcount1) - v0, 1);
        check({tag, " shld_pulses"}, shld_falls - f0, 1);
        check({tag, " shld_low_cycles"}, shld_low_cyc - l0, load_of(sel));
        check({tag, " serclk_rises"}, serclk_rises - r0, 7);
    endtask

    typedef struct {
        int         sel;
        logic [7:0] c1;
        logic [7:0] c2;
        logic       a;
        logic [15:0] exp;
    } vec_t;

    vec_t vecs[6];

    initial begin
        #200us;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int v0, q0, r0, k;
        logic [7:0] rc1, rc2;
        logic       ra;
        int         rsel;

        vecs[0] = '{1, 8'hA5, 8'hA4, 1'b1, 16'hA5A5};
        vecs[1] = '{1, 8'hFF, 8'hFF, 1'b1, 16'hFFFF};
        vecs[2] = '{1, 8'h00, 8'h01, 1'b0, 16'h0000};
        vecs[3] = '{0, 8'h84, 8'h00, 1'b0, 16'h8400};
        vecs[4] = '{0, 8'h60, 8'hFF, 1'b1, 16'h60FF};
        vecs[5] = '{0, 8'h60, 8'hFF, 1'b0, 16'h60FE};

        reset      = 1'b0;
        memen1     = 1'b1;
        memen2     = 1'b1;
        a15        = 1'b0;
        chain1_val = 8'h00;
        chain2_val = 8'h00;
        repeat (3) tick();
        check("reset shld", int'(shld1), 1);
        check("reset serclk", int'(serclk1), 0);
        check("reset address", int'(addr1), 0);
        check("reset valid", int'(valid1), 0);
        check("reset busy", int'(busy1), 0);
        check("reset address dut2", int'(addr2), 0);
        reset = 1'b1;
        repeat (3) tick();

        for (int i = 0; i < 6; i++) begin
            run_capture($sformatf("vec%0d", i), vecs[i].sel, vecs[i].c1, vecs[i].c2, vecs[i].a, vecs[i].exp);
        end

        // Abort: memen back high 150 ns after falling.
        chain1_val = 8'h11;
        chain2_val = 8'h22;
        a15        = 1'b1;
        repeat (4) tick();
        v0 = vcount1;
        memen1 = 1'b0;
        repeat (15) tick();
        check("abort busy_before", int'(busy1), 1);
        memen1 = 1'b1;
        repeat (3) tick();
        check("abort busy_low", int'(busy1), 0);
        check("abort shld", int'(shld1), 1);
        check("abort serclk", int'(serclk1), 0);
        repeat (50) tick();
        check("abort no_valid", vcount1 - v0, 0);
        check("abort address_kept", int'(addr1), 16'h60FE);

        // Back-to-back: falls 700 ns apart, sub-cycle memen glitch in the second capture.
        a15        = 1'b0;
        chain1_val = 8'h84;
        chain2_val = 8'h00;
        repeat (4) tick();
        v0 = vcount1;
        q0 = cap1_q.size();
        memen1 = 1'b0;
        repeat (40) tick();
        chain1_val = 8'h98;
        repeat (10) tick();
        memen1 = 1'b1;
        repeat (20) tick();
        memen1 = 1'b0;
        repeat (20) tick();
        memen1 = 1'b1;
        #3;
        memen1 = 1'b0;
        repeat (40) tick();
        memen1 = 1'b1;
        repeat (6) tick();
        check("b2b valid_count", vcount1 - v0, 2);
        check("b2b first", (cap1_q.size() > q0) ? int'(cap1_q[q0]) : -1, 16'h8400);
        check("b2b second", (cap1_q.size() > q0 + 1) ? int'(cap1_q[q0 + 1]) : -1, 16'h9800);

        for (int i = 0; i < 16; i++) begin
            rsel = int'($urandom_range(0, 1));
            rc1  = 8'($urandom);
            rc2  = 8'($urandom);
            ra   = 1'($urandom_range(0, 1));
            run_capture($sformatf("rand%0d", i), rsel, rc1, rc2, ra, ref_addr(rc1, rc2, ra));
        end

        // Reset during CLKHI of bit 3 (after the fourth SRCLK rise).
        chain1_val = 8'h3C;
        chain2_val = 8'hC3;
        repeat (4) tick();
        r0 = serclk_rises;
        memen1 = 1'b0;
        k = 0;
        while ((serclk_rises - r0) < 4 && k < 200) begin
            tick();
            k++;
        end
        check("rst_mid rises_before", serclk_rises - r0, 4);
        check("rst_mid busy_before", int'(busy1), 1);
        #2;
        reset = 1'b0;
        #1;
        check("rst_mid shld", int'(shld1), 1);
        check("rst_mid serclk", int'(serclk1), 0);
        check("rst_mid busy", int'(busy1), 0);
        check("rst_mid address", int'(addr1), 0);
        memen1 = 1'b1;
        v0 = vcount1;
        repeat (4) tick();
        reset = 1'b1;
        repeat (50) tick();
        check("rst_mid no_valid", vcount1 - v0, 0);
        check("rst_mid address_after", int'(addr1), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
